// File: rtl/sample_frame_buffer.sv
// sample_frame_buffer: ping-pong framer that packs decimated samples into FRAME_LEN frames
// and streams them oldest-first over valid/ready, dropping and counting samples on overrun.
module sample_frame_buffer #(
    parameter int WIDTH     = 16,
    parameter int FRAME_LEN = 256
) (
    input  logic                         clk_in,
    input  logic                         rst_in,
    input  logic [WIDTH-1:0]             sample_in,
    input  logic                         sample_valid_in,
    output logic [WIDTH-1:0]             frame_data_out,
    output logic                         frame_valid_out,
    input  logic                         frame_ready_in,
    output logic                         frame_last_out,
    output logic [$clog2(FRAME_LEN)-1:0] frame_index_out,
    output logic                         overrun_out,
    output logic [15:0]                  dropped_count_out
);
    localparam int IW = $clog2(FRAME_LEN);
    localparam logic [IW-1:0] LAST = IW'(FRAME_LEN - 1);
    localparam logic [1:0] EMPTY = 2'd0, FILLING = 2'd1, FULL = 2'd2, READING = 2'd3;
    localparam logic IDLE = 1'b0, STREAM = 1'b1;

    logic [WIDTH-1:0] r_mem [2][FRAME_LEN];
    logic [1:0]       r_st [2];
    logic             r_wr_bank, r_rd_bank, r_rd_state, r_overrun;
    logic [IW-1:0]    r_wr_idx, r_rd_idx;
    logic [WIDTH-1:0] r_data;
    logic [15:0]      r_dropped;
    logic             w_hs, w_last, w_wr_ok;
    logic [1:0]       w_rsel, w_wsel, w_free, w_into, w_done, w_avail, w_take;
    logic [IW-1:0]    w_nidx;

    // Frames always fill banks alternately, so both pointers simply toggle per frame.
    // A bank completing this cycle counts as available, giving one-cycle strobe-to-valid latency.
    assign w_rsel  = r_rd_bank ? 2'b10 : 2'b01;
    assign w_wsel  = r_wr_bank ? 2'b10 : 2'b01;
    assign w_hs    = r_rd_state == STREAM && frame_ready_in;
    assign w_last  = r_rd_idx == LAST;
    assign w_free  = (w_hs && w_last) ? w_rsel : 2'b00;
    assign w_wr_ok = sample_valid_in && (r_st[r_wr_bank] == EMPTY || r_st[r_wr_bank] == FILLING
                     || (w_free & w_wsel) != 2'b00);
    assign w_into  = w_wr_ok ? w_wsel : 2'b00;
    assign w_done  = (r_wr_idx == LAST) ? w_into : 2'b00;
    assign w_avail = {r_st[1] == FULL, r_st[0] == FULL} | w_done;
    assign w_take  = (r_rd_state == IDLE) ? (w_rsel & w_avail) :
                     (w_free != 2'b00) ? (~w_rsel & w_avail) : 2'b00;
    assign w_nidx  = r_rd_idx + 1'b1;

    function automatic logic [1:0] next_st(input logic [1:0] st, input logic take, done, into, free);
        return take ? READING : done ? FULL : into ? FILLING : free ? EMPTY : st;
    endfunction

    always_ff @(posedge clk_in) begin
        if (w_wr_ok) r_mem[r_wr_bank][r_wr_idx] <= sample_in;
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_st[0]   <= EMPTY;
            r_st[1]   <= EMPTY;
            r_wr_bank <= 1'b0;
            r_wr_idx  <= '0;
            r_overrun <= 1'b0;
            r_dropped <= '0;
        end else begin
            r_st[0] <= next_st(r_st[0], w_take[0], w_done[0], w_into[0], w_free[0]);
            r_st[1] <= next_st(r_st[1], w_take[1], w_done[1], w_into[1], w_free[1]);
            if (w_wr_ok) begin
                r_wr_idx  <= r_wr_idx + 1'b1;
                r_wr_bank <= r_wr_bank ^ (r_wr_idx == LAST);
            end else if (sample_valid_in) begin
                r_overrun <= 1'b1;
                r_dropped <= r_dropped + 16'(r_dropped != 16'hFFFF);
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_rd_state <= IDLE;
            r_rd_bank  <= 1'b0;
            r_rd_idx   <= '0;
            r_data     <= '0;
        end else if (r_rd_state == IDLE) begin
            if (w_take != 2'b00) begin
                r_rd_state <= STREAM;
                r_rd_idx   <= '0;
                r_data     <= r_mem[r_rd_bank][0];
            end
        end else if (w_hs && !w_last) begin
            r_rd_idx <= w_nidx;
            r_data   <= r_mem[r_rd_bank][w_nidx];
        end else if (w_hs) begin
            r_rd_bank <= ~r_rd_bank;
            r_rd_idx  <= '0;
            if (w_take != 2'b00) r_data <= r_mem[~r_rd_bank][0];
            else r_rd_state <= IDLE;
        end
    end

    assign frame_data_out    = r_data;
    assign frame_valid_out   = r_rd_state == STREAM;
    assign frame_last_out    = r_rd_state == STREAM && w_last;
    assign frame_index_out   = r_rd_idx;
    assign overrun_out       = r_overrun;
    assign dropped_count_out = r_dropped;
endmodule

// File: tb/tb_sample_frame_buffer.sv
// tb_sample_frame_buffer: scoreboard bench for sample_frame_buffer with FRAME_LEN=8.
module tb_sample_frame_buffer;
    localparam int FL = 8;
    typedef struct packed { logic [15:0] d; logic [2:0] i; } beat_t;

    logic        clk = 1'b0, rst_in = 1'b1, sample_valid_in = 1'b0, frame_ready_in = 1'b0;
    logic        rdy_lvl = 1'b1, rdy_tog = 1'b0;
    logic [15:0] sample_in = '0;
    logic [15:0] frame_data_out, dropped_count_out;
    logic        frame_valid_out, frame_last_out, overrun_out;
    logic [2:0]  frame_index_out;
    beat_t       sb_q[$];
    int          n_chk = 0, n_err = 0, kept_n = 0, n_stall = 0;

    sample_frame_buffer #(.WIDTH(16), .FRAME_LEN(FL)) dut (
        .clk_in(clk), .rst_in(rst_in), .sample_in(sample_in), .sample_valid_in(sample_valid_in),
        .frame_data_out(frame_data_out), .frame_valid_out(frame_valid_out),
        .frame_ready_in(frame_ready_in), .frame_last_out(frame_last_out),
        .frame_index_out(frame_index_out), .overrun_out(overrun_out),
        .dropped_count_out(dropped_count_out)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        frame_ready_in = rdy_tog ? ~frame_ready_in : rdy_lvl;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Every presented beat must match the oldest expected sample, stalled or not.
    always @(negedge clk) begin
        if (!rst_in && frame_valid_out) begin
            if (sb_q.size() == 0) chk("beat_expected", 32'(sb_q.size()), 1);
            else begin
                chk("data", frame_data_out, sb_q[0].d);
                chk("index", frame_index_out, sb_q[0].i);
                chk("last", frame_last_out, sb_q[0].i == 3'd7);
                if (frame_ready_in) void'(sb_q.pop_front());
                else n_stall++;
            end
        end
    end

    task automatic send(input logic [15:0] d, input bit keep);
        @(posedge clk); #1;
        sample_valid_in = 1'b1;
        sample_in = d;
        if (keep) begin
            sb_q.push_back({d, 3'(kept_n % FL)});
            kept_n++;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            sample_valid_in = 1'b0;
        end
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while ((sb_q.size() != 0 || frame_valid_out) && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk(tag, sb_q.size(), 0);
        chk({tag, "_valid"}, frame_valid_out, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int g, s0;
        idle(3);
        chk("rst_valid", frame_valid_out, 0);
        chk("rst_last", frame_last_out, 0);
        chk("rst_index", frame_index_out, 0);
        chk("rst_data", frame_data_out, 0);
        chk("rst_overrun", overrun_out, 0);
        chk("rst_count", dropped_count_out, 0);
        rst_in = 1'b0;

        // 1: single frame, ready high
        for (int k = 1; k <= 8; k++) send(16'(k), 1'b1);
        chk("t1_pre_valid", frame_valid_out, 0);
        idle(1);
        chk("t1_lat_valid", frame_valid_out, 1);
        chk("t1_lat_index", frame_index_out, 0);
        drain("t1_drain");

        // 2: ready toggling
        s0 = n_stall;
        rdy_tog = 1'b1;
        for (int k = 1; k <= 8; k++) send(16'(100 + k), 1'b1);
        idle(1);
        drain("t2_drain");
        chk("t2_stalls_seen", n_stall != s0, 1);
        rdy_tog = 1'b0;

        // 3: overrun while consumer stalled
        rdy_lvl = 1'b0;
        idle(2);
        chk("t3_overrun_pre", overrun_out, 0);
        chk("t3_count_pre", dropped_count_out, 0);
        for (int k = 1; k <= 24; k++) send(16'(200 + k), k <= 16);
        idle(1);
        chk("t3_overrun", overrun_out, 1);
        chk("t3_count", dropped_count_out, 8);
        chk("t3_valid_stalled", frame_valid_out, 1);
        chk("t3_index_stalled", frame_index_out, 0);

        // 4: two buffered frames drain back to back
        rdy_lvl = 1'b1;
        g = 0;
        @(negedge clk);
        while (!frame_ready_in && g < 10) begin @(negedge clk); g++; end
        for (int k = 0; k < 16; k++) begin
            chk("t4_no_bubble", frame_valid_out, 1);
            @(negedge clk);
        end
        chk("t4_end_valid", frame_valid_out, 0);
        chk("t4_q_empty", sb_q.size(), 0);

        // 5: strobe during last handshake with both banks occupied
        rdy_lvl = 1'b0;
        idle(1);
        for (int k = 1; k <= 16; k++) send(16'(300 + k), 1'b1);
        idle(1);
        rdy_lvl = 1'b1;
        g = 0;
        @(negedge clk);
        while (!(frame_valid_out && frame_ready_in && frame_last_out) && g < 100) begin
            @(negedge clk);
            g++;
        end
        chk("t5_last_hs", frame_valid_out && frame_ready_in && frame_last_out, 1);
        sample_valid_in = 1'b1;
        sample_in = 16'd399;
        sb_q.push_back({16'd399, 3'(kept_n % FL)});
        kept_n++;
        idle(1);
        chk("t5_count", dropped_count_out, 8);
        for (int k = 0; k < 7; k++) send(16'(400 + k), 1'b1);
        idle(1);
        drain("t5_drain");
        chk("t5_count_end", dropped_count_out, 8);

        // 6: reset mid-stream
        for (int k = 1; k <= 8; k++) send(16'(500 + k), 1'b1);
        idle(1);
        g = 0;
        @(negedge clk);
        while (!(frame_valid_out && frame_index_out == 3'd2) && g < 50) begin
            @(negedge clk);
            g++;
        end
        chk("t6_beat3", frame_index_out, 2);
        rst_in = 1'b1;
        @(posedge clk); #1;
        sb_q.delete();
        kept_n = 0;
        chk("t6_valid", frame_valid_out, 0);
        chk("t6_overrun", overrun_out, 0);
        chk("t6_count", dropped_count_out, 0);
        chk("t6_index", frame_index_out, 0);
        chk("t6_last", frame_last_out, 0);
        rst_in = 1'b0;
        for (int k = 1; k <= 8; k++) send(16'(600 + k), 1'b1);
        idle(1);
        drain("t6_drain");
        chk("t6_overrun_end", overrun_out, 0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
